// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked pipeline stages: FSM state encoding
// and default payload / stall-counter widths.
package pipe_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  // EMPTY: nothing held, ONE: main entry valid, TWO: main and skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear. Clear wins over increment;
// the count holds at all-ones once reached.
module sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // counter register: reset, then clear, then saturating increment
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage with flush and a saturating stall counter.
// Build option: define PIPE_STAGE_HS_SKID_EN for a two-entry skid buffer
// with a registered o_rdy; otherwise a single entry with o_rdy = !o_vld || i_rdy.
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high at the rising edge. Once o_vld rises it stays high with o_data
// stable until a downstream transfer, flush or reset; flush beats both
// transfers and drops any same-cycle upstream payload.
import pipe_pkg::*;

module pipe_stage_hs #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_flush,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_stall_cnt,
  output state_t           dbg_state
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic             up;
  logic             down;
  logic             stall;

  assign up        = i_vld && o_rdy;
  assign down      = o_vld && i_rdy;
  assign stall     = o_vld && !i_rdy;
  assign o_data    = main_q;
  assign dbg_state = state_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

`ifdef PIPE_STAGE_HS_SKID_EN
  logic [WIDTH-1:0] skid_q;
  logic             rdy_q;

  // next-state: fill on accept, promote skid on drain, flush empties
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (up) state_d = ONE;
        ONE: begin
          if (up && !down)      state_d = TWO;
          else if (!up && down) state_d = EMPTY;
        end
        TWO:     if (down) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // payload registers: new data lands in main when main is free this cycle,
  // otherwise in skid; skid moves to main when main drains
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!i_flush) begin
      case (state_q)
        EMPTY: if (up) main_q <= i_data;
        ONE: begin
          if (up && down)  main_q <= i_data;
          else if (up)     skid_q <= i_data;
        end
        TWO:   if (down) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  // ready is registered from the next state so i_rdy never reaches o_rdy combinationally
  always_ff @(posedge clk) begin
    if (rst) rdy_q <= 1'b1;
    else     rdy_q <= (state_d != TWO);
  end

  // outputs decoded from state
  always_comb begin
    o_vld = (state_q != EMPTY);
    o_rdy = rdy_q;
  end
`else
  // next-state: single entry, refilled in place on simultaneous in/out
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (up) state_d = ONE;
        ONE:     if (!up && down) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // payload register loads only on an accepted, unflushed upstream transfer
  always_ff @(posedge clk) begin
    if (rst)                 main_q <= '0;
    else if (up && !i_flush) main_q <= i_data;
  end

  // outputs: ready when empty or when the held entry leaves this cycle
  always_comb begin
    o_vld = (state_q != EMPTY);
    o_rdy = (state_q == EMPTY) || i_rdy;
  end
`endif

  sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .clr (i_cnt_clr),
    .cnt (o_stall_cnt)
  );

endmodule
